gol_frame_store: RTL and testbench
==================================

Name: gol_frame_store

Overview:
- Parametrised successor to the fixed two-bank Game-of-Life frame storage.
- Owns NUM_BANKS cell memories (2 = double buffer, 3 = triple buffer) and the bank-rotation state machine.
- Owns the power-up random seeding and the display/engine port muxing.
- Sits between gol_engine and svo_hdmi in the pixel-clock domain.
- Triple mode lets the engine run without waiting for video start-of-frame.

Parameters:
- ADDR_W, 16, cell address width (grid = 2^ADDR_W cells).
- DATA_W, 4, bits per cell (species code; 0 = dead).
- NUM_BANKS, 2, 2 or 3; any other value is an elaboration error.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- INIT_FILL, 1, 1 = random seed pattern, 0 = clear to zero.

Ports:
- clk  in  1  pixel clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- video_sof  in  1  one-cycle pulse at start of displayed frame.
- disp_addr  in  ADDR_W  display read address.
- disp_dout  out  DATA_W  display data, 1-cycle latency.
- eng_rd_addr  in  ADDR_W  engine read address (current generation).
- eng_rd_dout  out  DATA_W  engine read data, 1-cycle latency.
- eng_wr_en  in  1  engine write strobe (next generation).
- eng_wr_addr  in  ADDR_W  engine write address.
- eng_wr_data  in  DATA_W  engine write data.
- gen_done  in  1  pulse: write bank fully written.
- gen_ready  out  1  engine may start/continue a generation.
- init_done  out  1  seeding finished.
- front_idx  out  2  bank currently displayed.
- gen_count  out  16  committed generations; wraps at 16'hFFFF -> 0.
- swap_pending  out  1  double mode: finished generation awaiting sof.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: all outputs 0; LFSR = SEED; bank indices D = 0, R = 0, W = 1; state INIT. Memory contents are not reset.
- Reset asserted mid-operation: immediate return to the values above, and INIT restarts from address 0.
- States: INIT, RUN, WAIT_SOF (WAIT_SOF is double mode only).
- INIT:
  - One address per cycle, 0..2^ADDR_W-1, written into every bank simultaneously.
  - Write data: INIT_FILL=1 writes lfsr[DATA_W-1:0] when lfsr[15:14]==2'b00, else 0. INIT_FILL=0 writes 0.
  - LFSR is 16-bit Galois, mask 16'hB400, steps every INIT cycle.
  - After the last address: next cycle init_done=1, gen_ready=1, state RUN.
  - Engine writes and gen_done during INIT are ignored; gen_done during INIT sets err.
- Bank roles:
  - D = display bank, read by disp_addr.
  - R = engine-read bank.
  - W = engine-write bank.
  - Invariant: W != D and W != R.
- Double mode: R tracks D.
  - In RUN, gen_done -> gen_ready=0, swap_pending=1, state WAIT_SOF.
  - In WAIT_SOF, video_sof -> D<=W, W<=old D, gen_count+1, swap_pending=0, gen_ready=1, state RUN.
  - gen_done and video_sof in the same RUN cycle -> swap takes effect in that cycle; WAIT_SOF is skipped.
  - gen_done in WAIT_SOF -> ignored, err=1.
- Triple mode: stays in RUN; gen_ready stays 1 after init.
  - gen_done -> R<=W, W<=3-D-W, gen_count+1.
  - video_sof -> D<=R.
  - Both in the same cycle: gen_done first, then D takes the new R (W_old).
- Memory ports:
  - Per-bank port A serves display reads.
  - Per-bank port B writes when the bank is W and eng_wr_en=1 (or during INIT); otherwise it serves eng_rd_addr reads.
  - eng_wr_en=1 outside RUN is ignored.
- Read latency: the bank index is registered alongside the address. Data returned one cycle later comes from the bank selected at issue time, even across a swap.
- front_idx = D, registered.

Decomposition:
- Package gol_pkg holds: state enum {INIT, RUN, WAIT_SOF}; LFSR_MASK=16'hB400; the seed density rule; the bank-index width of 2.
- One sub-module, gol_bank_ram: simple dual-port, port A read-only, port B read/write, registered outputs. Instantiated NUM_BANKS times via generate.

Test Plan:
- ADDR_W=4, INIT_FILL=1, SEED=16'hACE1, reset released -> exactly 16 INIT cycles; init_done rises on cycle 17. All banks match a reference LFSR model; front_idx=0, gen_ready=1.
- Double mode, write 16 cells to W=1, pulse gen_done, video_sof 10 cycles later -> swap_pending=1 and gen_ready=0 for those 10 cycles. Then front_idx=1, gen_count=1, and disp_dout returns the written data.
- Double mode, gen_done and video_sof in the same cycle -> front_idx flips in that cycle; swap_pending never asserts; gen_count+1.
- Triple mode, three gen_done pulses with no sof -> gen_ready stays 1; W sequence 1 -> 2 -> 1 -> 2; gen_count=3; front_idx=0. Next sof -> front_idx = last R.
- Double mode, second gen_done while in WAIT_SOF -> err=1 and stays set; bank indices unchanged.
- rst_n asserted at INIT address 7 -> all outputs 0 asynchronously. After release, INIT restarts at address 0 and the LFSR restarts from SEED.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game-of-Life frame store: controller states,
// bank-role bundle, LFSR stepping and the random seed density rule.
package gol_pkg;

  // Bank indices never exceed 2, so two bits cover both buffer modes.
  localparam int BANK_W = 2;

  // Galois LFSR feedback mask (right-shifting form).
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef logic [BANK_W-1:0] bank_idx_t;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_SOF = 2'd2
  } state_t;

  // Roles of the banks: d = displayed, r = engine reads, w = engine writes.
  typedef struct packed {
    bank_idx_t d;
    bank_idx_t r;
    bank_idx_t w;
  } bank_roles_t;

  // One step of the 16-bit Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Roughly one cell in four is seeded alive: only when the top two bits are zero.
  function automatic logic seed_live(input logic [15:0] cur);
    return cur[15:14] == 2'b00;
  endfunction

  // With three banks numbered 0..2, the one that is neither a nor b.
  function automatic bank_idx_t third_bank(input bank_idx_t a, input bank_idx_t b);
    return bank_idx_t'(2'd3 - a - b);
  endfunction

endpackage

// File: rtl/gol_bank_ram.sv
// One cell memory bank: port A is a registered read port for the display,
// port B either writes or performs a registered read for the engine.
module gol_bank_ram
  import gol_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_dout,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] a_dout_q;
  logic [DATA_W-1:0] b_dout_q;

  // Display port: plain registered read.
  always_ff @(posedge clk) begin
    a_dout_q <= mem[a_addr];
  end

  // Engine port: write, or registered read when not writing (output holds on writes).
  always_ff @(posedge clk) begin
    if (b_we) begin
      mem[b_addr] <= b_din;
    end else begin
      b_dout_q <= mem[b_addr];
    end
  end

  assign a_dout = a_dout_q;
  assign b_dout = b_dout_q;

endmodule

// File: rtl/gol_frame_store.sv
// Game-of-Life frame storage: NUM_BANKS cell banks (2 = double, 3 = triple
// buffer), power-up seeding, bank-rotation controller and display/engine muxing.
module gol_frame_store
  import gol_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 4,
  parameter int          NUM_BANKS = 2,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          INIT_FILL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              video_sof,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_dout,
  input  logic [ADDR_W-1:0] eng_rd_addr,
  output logic [DATA_W-1:0] eng_rd_dout,
  input  logic              eng_wr_en,
  input  logic [ADDR_W-1:0] eng_wr_addr,
  input  logic [DATA_W-1:0] eng_wr_data,
  input  logic              gen_done,
  output logic              gen_ready,
  output logic              init_done,
  output logic [1:0]        front_idx,
  output logic [15:0]       gen_count,
  output logic              swap_pending,
  output logic              err
);

  // Reject unsupported configurations at elaboration.
  if (NUM_BANKS != 2 && NUM_BANKS != 3) begin : g_bad_num_banks
    $error("gol_frame_store: NUM_BANKS must be 2 or 3");
  end
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("gol_frame_store: SEED must be nonzero (LFSR would lock up)");
  end
  if (DATA_W > 16) begin : g_bad_data_w
    $error("gol_frame_store: DATA_W must not exceed the 16-bit LFSR width");
  end

  localparam bit               TRIPLE    = (NUM_BANKS == 3);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  // Controller state.
  state_t            state_q, state_d;
  bank_roles_t       roles_q, roles_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       gen_count_q, gen_count_d;
  logic              gen_ready_q, gen_ready_d;
  logic              init_done_q, init_done_d;
  logic              swap_pending_q, swap_pending_d;
  logic              err_q, err_d;

  // Read-side bookkeeping: bank chosen when a read was issued, plus a valid
  // flag so nothing leaks out of the banks while they are still being seeded.
  logic              rd_valid_q, rd_valid_d;
  bank_idx_t         disp_sel_q, disp_sel_d;
  bank_idx_t         eng_sel_q, eng_sel_d;

  logic [DATA_W-1:0] init_data;
  logic [DATA_W-1:0] a_dout_w [NUM_BANKS];
  logic [DATA_W-1:0] b_dout_w [NUM_BANKS];

  // Seed value for the address currently being initialised.
  always_comb begin
    init_data = '0;
    if (INIT_FILL != 0 && seed_live(lfsr_q)) begin
      init_data = lfsr_q[DATA_W-1:0];
    end
  end

  // Next-state logic: seeding sweep, then bank rotation on gen_done / video_sof.
  always_comb begin
    state_d        = state_q;
    roles_d        = roles_q;
    init_addr_d    = init_addr_q;
    lfsr_d         = lfsr_q;
    gen_count_d    = gen_count_q;
    gen_ready_d    = gen_ready_q;
    init_done_d    = init_done_q;
    swap_pending_d = swap_pending_q;
    err_d          = err_q;
    rd_valid_d     = (state_q != ST_INIT);
    disp_sel_d     = roles_q.d;
    eng_sel_d      = roles_q.r;

    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + ADDR_W'(1);
        lfsr_d      = lfsr_step(lfsr_q);
        // The engine has no business finishing a generation before seeding ends.
        if (gen_done) begin
          err_d = 1'b1;
        end
        if (init_addr_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
          gen_ready_d = 1'b1;
          init_addr_d = '0;
        end
      end

      ST_RUN: begin
        if (TRIPLE) begin
          // Finished generation becomes the read bank; engine moves to the
          // bank that is neither displayed nor just written.
          if (gen_done) begin
            roles_d.r   = roles_q.w;
            roles_d.w   = third_bank(roles_q.d, roles_q.w);
            gen_count_d = gen_count_q + 16'd1;
          end
          // Display picks up the newest complete generation (including one
          // committed in this very cycle).
          if (video_sof) begin
            roles_d.d = gen_done ? roles_q.w : roles_q.r;
          end
        end else if (gen_done) begin
          if (video_sof) begin
            // Frame boundary coincides with completion: swap immediately.
            roles_d.d   = roles_q.w;
            roles_d.r   = roles_q.w;
            roles_d.w   = roles_q.d;
            gen_count_d = gen_count_q + 16'd1;
          end else begin
            state_d        = ST_WAIT_SOF;
            gen_ready_d    = 1'b0;
            swap_pending_d = 1'b1;
          end
        end
      end

      ST_WAIT_SOF: begin
        // Engine must stay idle until the pending swap lands.
        if (gen_done) begin
          err_d = 1'b1;
        end
        if (video_sof) begin
          roles_d.d      = roles_q.w;
          roles_d.r      = roles_q.w;
          roles_d.w      = roles_q.d;
          gen_count_d    = gen_count_q + 16'd1;
          swap_pending_d = 1'b0;
          gen_ready_d    = 1'b1;
          state_d        = ST_RUN;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State registers; async reset restarts the seeding sweep from scratch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_INIT;
      roles_q        <= '{d: 2'd0, r: 2'd0, w: 2'd1};
      init_addr_q    <= '0;
      lfsr_q         <= SEED;
      gen_count_q    <= '0;
      gen_ready_q    <= 1'b0;
      init_done_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      err_q          <= 1'b0;
      rd_valid_q     <= 1'b0;
      disp_sel_q     <= '0;
      eng_sel_q      <= '0;
    end else begin
      state_q        <= state_d;
      roles_q        <= roles_d;
      init_addr_q    <= init_addr_d;
      lfsr_q         <= lfsr_d;
      gen_count_q    <= gen_count_d;
      gen_ready_q    <= gen_ready_d;
      init_done_q    <= init_done_d;
      swap_pending_q <= swap_pending_d;
      err_q          <= err_d;
      rd_valid_q     <= rd_valid_d;
      disp_sel_q     <= disp_sel_d;
      eng_sel_q      <= eng_sel_d;
    end
  end

  // Per-bank memories. Port B writes every bank during seeding, the write
  // bank while running, and otherwise serves engine reads.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_din;

    // Port B source select for this bank.
    always_comb begin
      b_we   = 1'b0;
      b_addr = eng_rd_addr;
      b_din  = eng_wr_data;
      if (state_q == ST_INIT) begin
        b_we   = 1'b1;
        b_addr = init_addr_q;
        b_din  = init_data;
      end else if (state_q == ST_RUN && eng_wr_en && roles_q.w == bank_idx_t'(gi)) begin
        b_we   = 1'b1;
        b_addr = eng_wr_addr;
      end
    end

    gol_bank_ram #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_ram (
      .clk   (clk),
      .a_addr(disp_addr),
      .a_dout(a_dout_w[gi]),
      .b_we  (b_we),
      .b_addr(b_addr),
      .b_din (b_din),
      .b_dout(b_dout_w[gi])
    );
  end

  // Return read data from the bank that was selected when the read was issued.
  always_comb begin
    disp_dout   = '0;
    eng_rd_dout = '0;
    if (rd_valid_q) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (disp_sel_q == bank_idx_t'(i)) begin
          disp_dout = a_dout_w[i];
        end
        if (eng_sel_q == bank_idx_t'(i)) begin
          eng_rd_dout = b_dout_w[i];
        end
      end
    end
  end

  assign gen_ready    = gen_ready_q;
  assign init_done    = init_done_q;
  assign front_idx    = roles_q.d;
  assign gen_count    = gen_count_q;
  assign swap_pending = swap_pending_q;
  assign err          = err_q;

endmodule

// File: tb/tb_gol_frame_store.sv
// Bench for gol_frame_store: a double-buffer and a triple-buffer instance run
// side by side on shared stimulus, checked against a behavioural model,
// a vector table and a few hand-written sequences.
module tb_gol_frame_store;

  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int NCELL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          video_sof;
  logic          gen_done;
  logic          eng_wr_en;
  logic [AW-1:0] disp_addr;
  logic [AW-1:0] eng_rd_addr;
  logic [AW-1:0] eng_wr_addr;
  logic [DW-1:0] eng_wr_data;

  logic [DW-1:0] disp_dout    [2];
  logic [DW-1:0] eng_rd_dout  [2];
  logic          gen_ready    [2];
  logic          init_done    [2];
  logic [1:0]    front_idx    [2];
  logic [15:0]   gen_count    [2];
  logic          swap_pending [2];
  logic          err          [2];

  gol_frame_store #(.ADDR_W(AW), .DATA_W(DW), .NUM_BANKS(2), .SEED(16'hACE1), .INIT_FILL(1)) dut_dbl (
    .clk(clk), .rst_n(rst_n), .video_sof(video_sof),
    .disp_addr(disp_addr), .disp_dout(disp_dout[0]),
    .eng_rd_addr(eng_rd_addr), .eng_rd_dout(eng_rd_dout[0]),
    .eng_wr_en(eng_wr_en), .eng_wr_addr(eng_wr_addr), .eng_wr_data(eng_wr_data),
    .gen_done(gen_done), .gen_ready(gen_ready[0]), .init_done(init_done[0]),
    .front_idx(front_idx[0]), .gen_count(gen_count[0]),
    .swap_pending(swap_pending[0]), .err(err[0])
  );

  gol_frame_store #(.ADDR_W(AW), .DATA_W(DW), .NUM_BANKS(3), .SEED(16'hACE1), .INIT_FILL(1)) dut_tri (
    .clk(clk), .rst_n(rst_n), .video_sof(video_sof),
    .disp_addr(disp_addr), .disp_dout(disp_dout[1]),
    .eng_rd_addr(eng_rd_addr), .eng_rd_dout(eng_rd_dout[1]),
    .eng_wr_en(eng_wr_en), .eng_wr_addr(eng_wr_addr), .eng_wr_data(eng_wr_data),
    .gen_done(gen_done), .gen_ready(gen_ready[1]), .init_done(init_done[1]),
    .front_idx(front_idx[1]), .gen_count(gen_count[1]),
    .swap_pending(swap_pending[1]), .err(err[1])
  );

  int checks = 0;
  int errors = 0;

  // Expected seed contents, derived once from the LFSR rules.
  logic [DW-1:0] ref_seed [NCELL];

  // Behavioural model, index 0 = double buffer, 1 = triple buffer.
  int            m_phase [2];   // 0 seeding, 1 running, 2 waiting for sof
  int            m_d [2];
  int            m_r [2];
  int            m_w [2];
  int            m_addr [2];
  int            m_cnt [2];
  bit            m_rdy [2];
  bit            m_done [2];
  bit            m_sp [2];
  bit            m_err [2];
  logic [DW-1:0] m_mem [2][3][NCELL];
  logic [DW-1:0] m_disp [2];
  logic [DW-1:0] m_eng [2];

  string inst_name [2] = '{"dbl", "tri"};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_phase[i] = 0;
    m_d[i] = 0; m_r[i] = 0; m_w[i] = 1;
    m_addr[i] = 0; m_cnt[i] = 0;
    m_rdy[i] = 0; m_done[i] = 0; m_sp[i] = 0; m_err[i] = 0;
    m_disp[i] = '0; m_eng[i] = '0;
  endtask

  // Advance model i by one clock edge using the inputs as they stand.
  task automatic model_step(input int i);
    int  nb;
    int  old_d;
    int  old_w;
    bit  do_swap;
    nb = (i == 0) ? 2 : 3;
    m_disp[i] = (m_phase[i] != 0) ? m_mem[i][m_d[i]][disp_addr]   : '0;
    m_eng[i]  = (m_phase[i] != 0) ? m_mem[i][m_r[i]][eng_rd_addr] : '0;
    if (m_phase[i] == 0) begin
      for (int b = 0; b < nb; b++) m_mem[i][b][m_addr[i]] = ref_seed[m_addr[i]];
      if (gen_done) m_err[i] = 1;
      if (m_addr[i] == NCELL - 1) begin
        m_phase[i] = 1; m_done[i] = 1; m_rdy[i] = 1;
      end
      m_addr[i]++;
    end else begin
      if (eng_wr_en && m_phase[i] == 1) m_mem[i][m_w[i]][eng_wr_addr] = eng_wr_data;
      if (nb == 3) begin
        if (gen_done) begin
          old_w = m_w[i];
          for (int b = 0; b < 3; b++) if (b != m_d[i] && b != old_w) m_w[i] = b;
          m_r[i] = old_w;
          m_cnt[i] = (m_cnt[i] + 1) % 65536;
        end
        if (video_sof) m_d[i] = m_r[i];
      end else begin
        do_swap = 0;
        if (m_phase[i] == 2) begin
          if (gen_done) m_err[i] = 1;
          do_swap = video_sof;
        end else if (gen_done) begin
          if (video_sof) do_swap = 1;
          else begin m_phase[i] = 2; m_sp[i] = 1; m_rdy[i] = 0; end
        end
        if (do_swap) begin
          old_d = m_d[i]; m_d[i] = m_w[i]; m_w[i] = old_d;
          m_cnt[i] = (m_cnt[i] + 1) % 65536;
          m_sp[i] = 0; m_rdy[i] = 1; m_phase[i] = 1;
        end
        m_r[i] = m_d[i];
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk({inst_name[i], ".front_idx"},    front_idx[i],    m_d[i]);
      chk({inst_name[i], ".gen_count"},    gen_count[i],    m_cnt[i]);
      chk({inst_name[i], ".gen_ready"},    gen_ready[i],    m_rdy[i]);
      chk({inst_name[i], ".init_done"},    init_done[i],    m_done[i]);
      chk({inst_name[i], ".swap_pending"}, swap_pending[i], m_sp[i]);
      chk({inst_name[i], ".err"},          err[i],          m_err[i]);
      chk({inst_name[i], ".disp_dout"},    disp_dout[i],    m_disp[i]);
      chk({inst_name[i], ".eng_rd_dout"},  eng_rd_dout[i],  m_eng[i]);
    end
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) model_reset(i);
      else model_step(i);
    end
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    video_sof = 0; gen_done = 0; eng_wr_en = 0;
    disp_addr = '0; eng_rd_addr = '0; eng_wr_addr = '0; eng_wr_data = '0;
  endtask

  // Hold reset over two edges, release, and time the seeding sweep.
  task automatic reset_and_init(input string tag);
    int n;
    rst_n = 0;
    for (int i = 0; i < 2; i++) model_reset(i);
    repeat (2) cycle();
    rst_n = 1;
    n = 0;
    while (!(init_done[0] === 1'b1 && init_done[1] === 1'b1) && n < 40) begin
      cycle();
      n++;
    end
    chk({tag, ".init_cycles"}, n, 16);
    $display("%s: seeding took %0d cycles", tag, n);
  endtask

  typedef struct {
    int sof; int gd;
    int dfront; int dsp; int drdy; int dcnt; int derr;
    int tfront; int tcnt;
  } vec_t;

  vec_t          tbl [9];
  logic [DW-1:0] wdat [NCELL];

  initial begin
    int l;
    tbl[0] = '{0, 1, 0, 1, 0, 0, 0, 0, 1};
    tbl[1] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[2] = '{1, 0, 1, 0, 1, 1, 0, 1, 1};
    tbl[3] = '{1, 1, 0, 0, 1, 2, 0, 2, 2};
    tbl[4] = '{0, 1, 0, 1, 0, 2, 0, 2, 3};
    tbl[5] = '{0, 1, 0, 1, 0, 2, 1, 2, 4};
    tbl[6] = '{1, 0, 1, 0, 1, 3, 1, 1, 4};
    tbl[7] = '{0, 1, 1, 1, 0, 3, 1, 1, 5};
    tbl[8] = '{1, 1, 0, 0, 1, 4, 1, 2, 6};

    l = 'hACE1;
    for (int a = 0; a < NCELL; a++) begin
      ref_seed[a] = ((l >> 14) == 0) ? DW'(l % 16) : '0;
      l = (l >> 1) ^ (((l & 1) != 0) ? 'hB400 : 0);
    end

    idle_inputs();
    rst_n = 0;
    for (int i = 0; i < 2; i++) model_reset(i);
    #1;
    chk("reset.front_idx", front_idx[0], 0);
    chk("reset.gen_ready", gen_ready[1], 0);

    // Power-up seeding and readback of bank 0 on both ports.
    reset_and_init("init");
    chk("init.front_idx", front_idx[0], 0);
    chk("init.gen_ready", gen_ready[0], 1);
    for (int a = 0; a < NCELL; a++) begin
      disp_addr = AW'(a);
      eng_rd_addr = AW'((a + 5) % NCELL);
      cycle();
      chk("seed.disp_dbl", disp_dout[0], ref_seed[a]);
      chk("seed.disp_tri", disp_dout[1], ref_seed[a]);
      chk("seed.eng_dbl", eng_rd_dout[0], ref_seed[(a + 5) % NCELL]);
    end

    // Vector table of gen_done / video_sof combinations.
    for (int v = 0; v < 9; v++) begin
      video_sof = (tbl[v].sof != 0);
      gen_done  = (tbl[v].gd != 0);
      cycle();
      video_sof = 0; gen_done = 0;
      chk("tbl.dbl_front", front_idx[0], tbl[v].dfront);
      chk("tbl.dbl_swap_pending", swap_pending[0], tbl[v].dsp);
      chk("tbl.dbl_gen_ready", gen_ready[0], tbl[v].drdy);
      chk("tbl.dbl_gen_count", gen_count[0], tbl[v].dcnt);
      chk("tbl.dbl_err", err[0], tbl[v].derr);
      chk("tbl.tri_front", front_idx[1], tbl[v].tfront);
      chk("tbl.tri_gen_count", gen_count[1], tbl[v].tcnt);
      chk("tbl.tri_gen_ready", gen_ready[1], 1);
      $display("vec %0d sof=%0d gd=%0d dbl front=%0d cnt=%0d err=%0d tri front=%0d cnt=%0d",
               v, tbl[v].sof, tbl[v].gd, front_idx[0], gen_count[0], err[0], front_idx[1], gen_count[1]);
    end

    // Asynchronous reset from a busy state: outputs clear before any edge.
    #2 rst_n = 0;
    for (int i = 0; i < 2; i++) model_reset(i);
    #1;
    compare_all();
    chk("areset.dbl_err", err[0], 0);
    chk("areset.tri_front", front_idx[1], 0);
    chk("areset.tri_gen_count", gen_count[1], 0);
    cycle();

    // Reset during seeding, with a stray gen_done and engine write in between.
    rst_n = 1;
    repeat (3) cycle();
    gen_done = 1; eng_wr_en = 1; eng_wr_addr = 4'hF; eng_wr_data = 4'h9;
    cycle();
    gen_done = 0; eng_wr_en = 0;
    repeat (3) cycle();
    chk("init_gd.dbl_err", err[0], 1);
    chk("init_gd.tri_err", err[1], 1);
    #2 rst_n = 0;
    for (int i = 0; i < 2; i++) model_reset(i);
    #1;
    compare_all();
    chk("midinit.err_cleared", err[0], 0);
    $display("reset asserted mid-seeding at address 7");
    reset_and_init("reinit");
    for (int a = 0; a < NCELL; a++) begin
      disp_addr = AW'(a);
      cycle();
      chk("reseed.disp_tri", disp_dout[1], ref_seed[a]);
    end

    // Double mode: full write, gen_done, sof ten cycles later.
    reset_and_init("swap10");
    for (int a = 0; a < NCELL; a++) begin
      wdat[a] = DW'($urandom_range(1, 15));
      eng_wr_en = 1; eng_wr_addr = AW'(a); eng_wr_data = wdat[a];
      cycle();
    end
    eng_wr_en = 0;
    gen_done = 1;
    cycle();
    gen_done = 0;
    chk("swap10.swap_pending", swap_pending[0], 1);
    chk("swap10.gen_ready", gen_ready[0], 0);
    for (int k = 0; k < 9; k++) begin
      cycle();
      chk("swap10.swap_pending", swap_pending[0], 1);
      chk("swap10.gen_ready", gen_ready[0], 0);
    end
    video_sof = 1;
    cycle();
    video_sof = 0;
    chk("swap10.front_idx", front_idx[0], 1);
    chk("swap10.gen_count", gen_count[0], 1);
    chk("swap10.swap_cleared", swap_pending[0], 0);
    chk("swap10.tri_front", front_idx[1], 1);
    for (int a = 0; a < NCELL; a++) begin
      disp_addr = AW'(a);
      cycle();
      chk("swap10.disp_dbl", disp_dout[0], wdat[a]);
      chk("swap10.disp_tri", disp_dout[1], wdat[a]);
    end

    // Triple mode: three generations without sof; double mode flags the overrun.
    reset_and_init("triple3");
    disp_addr = '0;
    for (int k = 0; k < 3; k++) begin
      eng_wr_en = 1; eng_wr_addr = '0; eng_wr_data = DW'(k + 5);
      cycle();
      eng_wr_en = 0; gen_done = 1;
      cycle();
      gen_done = 0;
      chk("triple3.gen_ready", gen_ready[1], 1);
      cycle();
      $display("triple3: generation %0d committed, tri count=%0d", k + 1, gen_count[1]);
    end
    chk("triple3.gen_count", gen_count[1], 3);
    chk("triple3.front_idx", front_idx[1], 0);
    chk("triple3.dbl_err", err[0], 1);
    chk("triple3.dbl_front", front_idx[0], 0);
    video_sof = 1;
    cycle();
    video_sof = 0;
    cycle();
    chk("triple3.front_after_sof", front_idx[1], 1);
    chk("triple3.disp_tri", disp_dout[1], 7);
    chk("triple3.dbl_front_after_sof", front_idx[0], 1);
    chk("triple3.disp_dbl", disp_dout[0], 5);
    chk("triple3.dbl_err_sticky", err[0], 1);

    // Randomised traffic against the model.
    reset_and_init("random");
    for (int c = 0; c < 600; c++) begin
      video_sof   = ($urandom_range(0, 7) == 0);
      gen_done    = ($urandom_range(0, 9) == 0);
      eng_wr_en   = ($urandom_range(0, 1) == 1);
      disp_addr   = AW'($urandom_range(0, NCELL - 1));
      eng_rd_addr = AW'($urandom_range(0, NCELL - 1));
      eng_wr_addr = AW'($urandom_range(0, NCELL - 1));
      eng_wr_data = DW'($urandom_range(0, 15));
      cycle();
    end
    idle_inputs();
    cycle();
    $display("random: dbl count=%0d tri count=%0d", gen_count[0], gen_count[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
